// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus stability-qualified debouncer for one asynchronous level input.
// d_out follows the synchronised input only after STABLE_CYCLES consecutive mismatching samples.
module sync_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter logic        RESET_VAL     = 1'b0,
    parameter int unsigned GLITCH_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    d_in,
    output logic                    d_out,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic                    busy,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

    localparam logic [CNT_WIDTH-1:0]    CNT_LAST   = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 mismatch;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= d_in;
            sync2 <= sync1;
        end
    end

    assign mismatch = (sync2 != d_out);

    // A single matching sample restarts qualification; an abandoned candidate counts as a glitch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_out      <= RESET_VAL;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (mismatch && (cnt == CNT_LAST)) begin
                d_out      <= sync2;
                cnt        <= '0;
                rise_pulse <= sync2;
                fall_pulse <= ~sync2;
            end else if (mismatch) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end else begin
                cnt <= '0;
                if ((cnt != '0) && (glitch_cnt != GLITCH_MAX)) begin
                    glitch_cnt <= glitch_cnt + GLITCH_WIDTH'(1);
                end
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Input-conditioning stage for a single asynchronous level signal (push-button, external strobe, off-chip status pin). It synchronises the raw input into the `clk` domain and filters bounce and glitches, holding its output until the input has been stable for a programmable number of cycles. It also emits one-cycle rise/fall pulses. `d_out` is the clean level that feeds the downstream register stages' `d_in`; the pulses serve as event strobes.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised-mismatch cycles required before `d_out` updates; legal range 2 .. 2^CNT_WIDTH-1.
- `CNT_WIDTH`, default 16: stability counter width.
- `RESET_VAL`, default 1'b0: reset level of the synchroniser flops and `d_out`.
- `GLITCH_WIDTH`, default 8: width of the glitch counter.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  reset is synchronous and active-low; sampled only on posedge `clk`.
- `d_in`  in  1  raw asynchronous input.
- `d_out`  out  1  debounced, registered level.
- `rise_pulse`  out  1  one-cycle high when `d_out` goes 0→1.
- `fall_pulse`  out  1  one-cycle high when `d_out` goes 1→0.
- `busy`  out  1  high while a candidate transition is being qualified (counter ≠ 0).
- `glitch_cnt`  out  GLITCH_WIDTH  saturating count of aborted candidates.

## Operation
- Synchroniser: two flops, `sync1 <= d_in`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Stability counter `cnt`, with `mismatch = (sync2 != d_out)`. Each edge:
  - If `mismatch` and `cnt == STABLE_CYCLES-1`: set `d_out <= sync2`, `cnt <= 0`, and pulse the matching edge output.
  - Else if `mismatch`: `cnt <= cnt + 1`.
  - Else: `cnt <= 0`. If `cnt != 0` at that point, the candidate is aborted and `glitch_cnt` increments, saturating at 2^GLITCH_WIDTH-1 with no wrap.
- A mismatch must persist for exactly STABLE_CYCLES consecutive edges. Any single matching sample restarts qualification from zero.
- `rise_pulse` and `fall_pulse` are registered and asserted in the same cycle `d_out` changes, for one cycle only. They are never both high, and never high without a `d_out` change.
- `busy` is combinational from the registered counter: `busy = (cnt != 0)`.
- `glitch_cnt` is cleared only by reset.

Reset (`reset_n` low at a posedge) has priority over everything, including mid-qualification and a pulse cycle. Resulting state:
- `sync1`, `sync2`, `d_out` = RESET_VAL
- `cnt` = 0, `busy` = 0
- `rise_pulse` = 0, `fall_pulse` = 0
- `glitch_cnt` = 0

Because the synchroniser resets to RESET_VAL, no spurious pulse is produced on reset release unless `d_in` differs from RESET_VAL. If it does, that difference is qualified normally.

## Timing
- Let edge 0 be the first posedge that samples a new stable `d_in`. Then:
  - `sync2` holds the new value after edge 1.
  - `cnt` = 1 after edge 2.
  - `d_out` and the pulse update after edge STABLE_CYCLES+1.
- Total latency: STABLE_CYCLES+2 posedges. With the default 4, `d_out` changes after edge 5.
- A pulse on `d_in` shorter than STABLE_CYCLES cycles (after synchronisation) never reaches `d_out`. It increments `glitch_cnt` by 1 if it reached `sync2`.
- Back-to-back qualified transitions are separated by at least STABLE_CYCLES cycles of `d_out` stability.
- All outputs except `busy` are flop outputs. `busy` has one gate level after `cnt`.

## Test plan
- Reset with `d_in`=0, hold `reset_n`=0 for 3 edges, then release → `d_out`=0, both pulses 0, `busy`=0, `glitch_cnt`=0 on every cycle.
- `d_in` 0→1 held (STABLE_CYCLES=4) → `d_out`=1 and `rise_pulse`=1 for exactly one cycle after edge 5 (edge 0 = first sample of 1). `busy` high after edges 2–4.
- Bounce: `d_in` high for 2 cycles, low for 1, then high steady → no output change during the bounce. `glitch_cnt`=1. `d_out` rises 5 edges after the final stable sample begins.
- 1→0 after a settled high → `fall_pulse` for one cycle, `rise_pulse` stays 0, `d_out`=0 at latency 6.
- Reset mid-operation: assert `reset_n`=0 while `cnt`=3 → next edge `cnt`=0, `d_out`=RESET_VAL, no pulse, `glitch_cnt`=0.
- GLITCH_WIDTH=2, apply 5 isolated 2-cycle glitches → `glitch_cnt` reads 1, 2, 3, 3, 3 (saturates, no wrap). `d_out` unchanged throughout.
